// File: rtl/regfile_access_seq_pkg.sv
// Shared constants, state encoding and request record for the register-file
// access sequencer.
package regfile_access_seq_pkg;

    localparam int N      = 16;               // data width, matches register N
    localparam int NREG   = 8;                // registers on the shared bus
    localparam int ADDR_W = $clog2(NREG);     // register index width

    // Sequencer states, 3-bit binary
    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WR    = 3'd2,
        ST_RD1   = 3'd3,
        ST_REL1  = 3'd4,
        ST_RD2   = 3'd5,
        ST_REL2  = 3'd6,
        ST_RESP  = 3'd7
    } state_t;

    // Control fields of one decode request, held for the whole sequence
    typedef struct packed {
        logic              wb_en;
        logic [ADDR_W-1:0] wb_addr;
        logic              rs1_en;
        logic [ADDR_W-1:0] rs1_addr;
        logic              rs2_en;
        logic [ADDR_W-1:0] rs2_addr;
    } req_t;

    // First read step still owed after any write-back: RD1, then RD2, else RESP
    function automatic state_t first_src(input logic rs1_en, input logic rs2_en);
        state_t s;
        if (rs1_en)      s = ST_RD1;
        else if (rs2_en) s = ST_RD2;
        else             s = ST_RESP;
        return s;
    endfunction

endpackage

// File: rtl/regfile_access_seq_if.sv
// Decode-side request/response and register-bank strobe/bus signals.
// master = decode stage plus register bank, slave = the sequencer.
interface regfile_access_seq_if;
    import regfile_access_seq_pkg::*;

    // decode request
    logic              req_valid;
    logic              req_ready;
    logic              rs1_en;
    logic              rs2_en;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [N-1:0]      wb_data;

    // register bank
    logic [NREG-1:0]   rf_write_en;
    logic [NREG-1:0]   rf_read_en;
    logic [NREG-1:0]   rf_end_read;
    logic [N-1:0]      rf_write_data;
    logic [N-1:0]      rf_bus;

    // response
    logic [N-1:0]      op1_data;
    logic [N-1:0]      op2_data;
    logic              rsp_valid;

    modport master (
        output req_valid, rs1_en, rs2_en, rs1_addr, rs2_addr,
               wb_en, wb_addr, wb_data, rf_bus,
        input  req_ready, rf_write_en, rf_read_en, rf_end_read,
               rf_write_data, op1_data, op2_data, rsp_valid
    );

    modport slave (
        input  req_valid, rs1_en, rs2_en, rs1_addr, rs2_addr,
               wb_en, wb_addr, wb_data, rf_bus,
        output req_ready, rf_write_en, rf_read_en, rf_end_read,
               rf_write_data, op1_data, op2_data, rsp_valid
    );

endinterface

// File: rtl/regfile_access_seq_onehot_dec.sv
// Register index to one-hot strobe vector, all zero when disabled.
module regfile_access_seq_onehot_dec
    import regfile_access_seq_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int NO = NREG
) (
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    output logic [NO-1:0] o_onehot
);

    // Set the single addressed bit when enabled
    always_comb begin
        o_onehot = '0;
        if (i_en) o_onehot[i_addr] = 1'b1;
    end

endmodule

// File: rtl/regfile_access_seq.sv
// Sequencer between decode and the bank of edge-strobed registers.
// A request becomes: optional write strobe, then for each distinct source a
// read strobe (register starts driving the shared bus) followed by a release
// strobe, then a one-cycle response. All outputs come straight from flops
// loaded with the decode of the next state, so every strobe is a clean
// one-cycle pulse.
module regfile_access_seq
    import regfile_access_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_access_seq_if.slave  bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_alive;      // low until the first edge after reset release
    req_t            r_req;
    req_t            w_req;        // live inputs in IDLE, held copy otherwise
    logic            w_accept;

    logic [NREG-1:0] w_wr_oh;
    logic [NREG-1:0] w_rd_oh;
    logic [NREG-1:0] w_rel_oh;
    logic            w_wr_en;
    logic            w_rd_en;
    logic            w_rel_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_rel_addr;
    logic            w_same_src;

    logic [NREG-1:0] r_write_en;
    logic [NREG-1:0] r_read_en;
    logic [NREG-1:0] r_end_read;
    logic [N-1:0]    r_write_data;
    logic [N-1:0]    r_op1;
    logic [N-1:0]    r_op2;
    logic            r_rsp_valid;
    logic            r_req_ready;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

    // Request fields seen by the sequencer: inputs are only looked at in IDLE
    always_comb begin
        w_req = r_req;
        if (r_state == ST_IDLE) begin
            w_req.wb_en    = bus.wb_en;
            w_req.wb_addr  = bus.wb_addr;
            w_req.rs1_en   = bus.rs1_en;
            w_req.rs1_addr = bus.rs1_addr;
            w_req.rs2_en   = bus.rs2_en;
            w_req.rs2_addr = bus.rs2_addr;
        end
    end

    // Both sources name the same register: read it once, copy into op2
    assign w_same_src = w_req.rs1_en && w_req.rs2_en &&
                        (w_req.rs1_addr == w_req.rs2_addr);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // Stay one registered cycle in FLUSH so its release strobe is seen
            ST_FLUSH: if (r_alive) w_state_nxt = ST_IDLE;
            ST_IDLE:  if (bus.req_valid)
                          w_state_nxt = w_req.wb_en ? ST_WR
                                                    : first_src(w_req.rs1_en, w_req.rs2_en);
            ST_WR:    w_state_nxt = first_src(w_req.rs1_en, w_req.rs2_en);
            ST_RD1:   w_state_nxt = ST_REL1;
            ST_REL1:  w_state_nxt = (w_req.rs2_en && !w_same_src) ? ST_RD2 : ST_RESP;
            ST_RD2:   w_state_nxt = ST_REL2;
            ST_REL2:  w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_FLUSH;
        endcase
    end

    // Strobe enables and addresses for the state being entered
    always_comb begin
        w_wr_en    = (w_state_nxt == ST_WR);
        w_rd_en    = (w_state_nxt == ST_RD1)  || (w_state_nxt == ST_RD2);
        w_rel_en   = (w_state_nxt == ST_REL1) || (w_state_nxt == ST_REL2);
        w_rd_addr  = (w_state_nxt == ST_RD2)  ? w_req.rs2_addr : w_req.rs1_addr;
        w_rel_addr = (w_state_nxt == ST_REL2) ? w_req.rs2_addr : w_req.rs1_addr;
    end

    regfile_access_seq_onehot_dec u_dec_wr (
        .i_en     (w_wr_en),
        .i_addr   (w_req.wb_addr),
        .o_onehot (w_wr_oh)
    );

    regfile_access_seq_onehot_dec u_dec_rd (
        .i_en     (w_rd_en),
        .i_addr   (w_rd_addr),
        .o_onehot (w_rd_oh)
    );

    regfile_access_seq_onehot_dec u_dec_rel (
        .i_en     (w_rel_en),
        .i_addr   (w_rel_addr),
        .o_onehot (w_rel_oh)
    );

    // State, held request and Moore strobe/handshake flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FLUSH;
            r_alive     <= 1'b0;
            r_req       <= '0;
            r_write_en  <= '0;
            r_read_en   <= '0;
            r_end_read  <= '0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_alive     <= 1'b1;
            if (w_accept) r_req <= w_req;
            r_write_en  <= w_wr_oh;
            r_read_en   <= w_rd_oh;
            // FLUSH releases every register in case one was left driving
            r_end_read  <= (w_state_nxt == ST_FLUSH) ? {NREG{1'b1}} : w_rel_oh;
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_req_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    // Write data and operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_data <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
        end else if (w_accept) begin
            // Disabled sources report zero, so clear both at the start
            if (bus.wb_en) r_write_data <= bus.wb_data;
            r_op1 <= '0;
            r_op2 <= '0;
        end else begin
            case (r_state)
                // Bus is driven by the register for the whole read cycle
                ST_RD1:  r_op1 <= bus.rf_bus;
                ST_RD2:  r_op2 <= bus.rf_bus;
                ST_REL1: if (w_same_src) r_op2 <= r_op1;
                default: ;
            endcase
        end
    end

    assign bus.rf_write_en   = r_write_en;
    assign bus.rf_read_en    = r_read_en;
    assign bus.rf_end_read   = r_end_read;
    assign bus.rf_write_data = r_write_data;
    assign bus.op1_data      = r_op1;
    assign bus.op2_data      = r_op2;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.req_ready     = r_req_ready;

endmodule

// File: tb/tb_regfile_access_seq.sv
// Directed bench: register-bank model on the strobes, expected operands and
// latency queued per request and checked when rsp_valid appears.
module tb_regfile_access_seq;
    import regfile_access_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_access_seq_if ifc ();

    regfile_access_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Edge-strobed register bank model
    logic [N-1:0] regs [NREG];
    logic         drv  [NREG];

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        always @(posedge ifc.rf_write_en[g]) regs[g] = ifc.rf_write_data;
        always @(posedge ifc.rf_read_en[g])  drv[g]  = 1'b1;
        always @(posedge ifc.rf_end_read[g]) drv[g]  = 1'b0;
    end

    always_comb begin
        ifc.rf_bus = 'z;
        for (int i = 0; i < NREG; i++) if (drv[i]) ifc.rf_bus = regs[i];
    end

    typedef struct {
        logic [N-1:0] op1;
        logic [N-1:0] op2;
        int           lat;
    } exp_t;

    exp_t         sb [$];
    logic [N-1:0] mregs [NREG];     // expected register contents
    int           n_assert = 0;
    int           n_fail   = 0;

    // per-cycle trace of the last request, index 1 = first cycle after acceptance
    logic [NREG-1:0] tw  [16];
    logic [NREG-1:0] tr  [16];
    logic [NREG-1:0] te  [16];
    logic [N-1:0]    twd [16];
    logic            trdy[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_drv();
        logic a = 1'b0;
        for (int i = 0; i < NREG; i++) a |= drv[i];
        return a;
    endfunction

    // Issue one request from IDLE, wait for the response, check it
    task automatic send(input logic wbe, input int wba, input logic [N-1:0] wbd,
                        input logic r1e, input int r1, input logic r2e, input int r2);
        exp_t e;
        exp_t got;
        int   lat = 0;
        if (wbe) mregs[wba] = wbd;
        e.op1 = r1e ? mregs[r1] : '0;
        e.op2 = r2e ? mregs[r2] : '0;
        e.lat = 1 + (wbe ? 1 : 0) + (r1e ? 2 : 0) + ((r2e && !(r1e && r1 == r2)) ? 2 : 0);
        sb.push_back(e);
        ifc.wb_en    = wbe;
        ifc.wb_addr  = ADDR_W'(wba);
        ifc.wb_data  = wbd;
        ifc.rs1_en   = r1e;
        ifc.rs1_addr = ADDR_W'(r1);
        ifc.rs2_en   = r2e;
        ifc.rs2_addr = ADDR_W'(r2);
        ifc.req_valid = 1'b1;
        tick();
        ifc.req_valid = 1'b0;
        // inputs must be ignored while busy
        ifc.wb_en    = 1'($urandom);
        ifc.wb_addr  = ADDR_W'($urandom);
        ifc.wb_data  = N'($urandom);
        ifc.rs1_en   = 1'($urandom);
        ifc.rs1_addr = ADDR_W'($urandom);
        ifc.rs2_en   = 1'($urandom);
        ifc.rs2_addr = ADDR_W'($urandom);
        for (int c = 1; c < 12; c++) begin
            tw[c] = ifc.rf_write_en;  tr[c] = ifc.rf_read_en;
            te[c] = ifc.rf_end_read;  twd[c] = ifc.rf_write_data;
            trdy[c] = ifc.req_ready;
            if (ifc.rsp_valid) begin
                lat = c;
                break;
            end
            chk("strobe_excl", {31'd0, ($countones(tr[c]) <= 1) && !(|tr[c] && |tw[c])}, 32'd1);
            tick();
        end
        got = sb.pop_front();
        if (lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
        chk("latency", lat, got.lat);
        chk("op1", ifc.op1_data, got.op1);
        chk("op2", ifc.op2_data, got.op2);
        tick();
        chk("rsp_pulse", ifc.rsp_valid, 1'b0);
        chk("ready_back", ifc.req_ready, 1'b1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_wr"},  ifc.rf_write_en, '0);
        chk({tag, "_rd"},  ifc.rf_read_en,  '0);
        chk({tag, "_rsp"}, ifc.rsp_valid,   1'b0);
    endtask

    initial begin
        int sum_rd;
        for (int i = 0; i < NREG; i++) begin
            regs[i] = '0; drv[i] = 1'b0; mregs[i] = '0;
        end
        // a register left driving from before reset
        regs[6] = 16'h6666; mregs[6] = 16'h6666; drv[6] = 1'b1;
        ifc.req_valid = 1'b0; ifc.wb_en = 1'b0; ifc.wb_addr = '0; ifc.wb_data = '0;
        ifc.rs1_en = 1'b0; ifc.rs1_addr = '0; ifc.rs2_en = 1'b0; ifc.rs2_addr = '0;

        // reset state
        tick(); tick();
        chk_quiet("reset");
        chk("reset_endrd", ifc.rf_end_read, '0);
        chk("reset_wdata", ifc.rf_write_data, '0);
        chk("reset_op1", ifc.op1_data, '0);
        chk("reset_op2", ifc.op2_data, '0);
        chk("reset_ready", ifc.req_ready, 1'b0);

        // release: one FLUSH cycle then IDLE
        rst_n = 1'b1;
        tick();
        chk("flush_endrd", ifc.rf_end_read, 8'hFF);
        chk("flush_ready", ifc.req_ready, 1'b0);
        chk("flush_bus_released", any_drv(), 1'b0);
        tick();
        chk("idle_endrd", ifc.rf_end_read, '0);
        chk("idle_ready", ifc.req_ready, 1'b1);
        chk_quiet("idle");

        // write-back only
        send(1'b1, 3, 16'hBEEF, 1'b0, 0, 1'b0, 0);
        chk("wb_wdata", twd[1], 16'hBEEF);
        chk("wb_strobe", tw[1], 8'h08);
        chk("wb_busy_ready", trdy[1], 1'b0);
        chk("wb_strobe_end", tw[2], 8'h00);
        chk("wb_reg3", regs[3], 16'hBEEF);

        // preload r1, r2 then read both
        send(1'b1, 1, 16'h0011, 1'b0, 0, 1'b0, 0);
        send(1'b1, 2, 16'h0022, 1'b0, 0, 1'b0, 0);
        send(1'b0, 0, 16'h0, 1'b1, 1, 1'b1, 2);
        chk("rd2_c1_rd", tr[1], 8'h02);
        chk("rd2_c2_rel", te[2], 8'h02);
        chk("rd2_c3_rd", tr[3], 8'h04);
        chk("rd2_c4_rel", te[4], 8'h04);

        // write then read the same register through both sources
        send(1'b1, 5, 16'h1234, 1'b1, 5, 1'b1, 5);
        sum_rd = 0;
        for (int c = 1; c <= 4; c++) sum_rd += $countones(tr[c]);
        chk("same_src_reads", sum_rd, 1);
        chk("same_src_wr", tw[1], 8'h20);
        chk("same_src_rd", tr[2], 8'h20);
        chk("same_src_rel", te[3], 8'h20);

        // nothing to do: ops cleared
        send(1'b0, 0, 16'h0, 1'b0, 0, 1'b0, 0);

        // rs2 only, and write-back with rs1 to the written register
        send(1'b0, 0, 16'h0, 1'b0, 0, 1'b1, 3);
        send(1'b1, 7, 16'hA5A5, 1'b1, 7, 1'b0, 0);
        send(1'b0, 0, 16'h0, 1'b1, 6, 1'b1, 7);

        // a few random requests against the model
        for (int k = 0; k < 8; k++)
            send(1'($urandom), int'($urandom_range(0, 7)), N'($urandom),
                 1'($urandom), int'($urandom_range(0, 7)),
                 1'($urandom), int'($urandom_range(0, 7)));

        // reset during RD2
        ifc.wb_en = 1'b0; ifc.rs1_en = 1'b1; ifc.rs1_addr = 3'd1;
        ifc.rs2_en = 1'b1; ifc.rs2_addr = 3'd2; ifc.req_valid = 1'b1;
        tick();
        ifc.req_valid = 1'b0;
        tick(); tick();
        chk("midrst_rd2", ifc.rf_read_en, 8'h04);
        rst_n = 1'b0;
        #1;
        chk_quiet("midrst");
        chk("midrst_endrd", ifc.rf_end_read, '0);
        chk("midrst_op1", ifc.op1_data, '0);
        chk("midrst_op2", ifc.op2_data, '0);
        chk("midrst_stuck", drv[2], 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_flush", ifc.rf_end_read, 8'hFF);
        chk("midrst_released", any_drv(), 1'b0);
        tick();
        chk("midrst_ready", ifc.req_ready, 1'b1);

        // back in service after the mid-sequence reset
        send(1'b0, 0, 16'h0, 1'b1, 2, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
